// File: rtl/rgb2ycbcr_job_ctrl_if.sv
// Stream-side handshake bundle of the RGB->YCbCr job controller.
//
// Handshake semantics: a transfer happens on a rising clock edge when
// valid and ready are both high in that cycle. A producer holds valid
// (and its payload) until the transfer completes; ready may depend
// combinationally on the consumer's own downstream ready (out_ready_i
// -> in_ready_o is such a path). conv_en_o and conv_in_valid_o are
// qualifiers for the converter datapath, not handshakes.
interface rgb2ycbcr_job_ctrl_if;
  logic in_valid_i;
  logic in_ready_o;
  logic conv_en_o;
  logic conv_in_valid_o;
  logic out_valid_o;
  logic out_ready_i;
  logic out_last_o;

  // Controller side
  modport master (
    input  in_valid_i,
    input  out_ready_i,
    output in_ready_o,
    output conv_en_o,
    output conv_in_valid_o,
    output out_valid_o,
    output out_last_o
  );

  // Streamer / downstream side
  modport slave (
    output in_valid_i,
    output out_ready_i,
    input  in_ready_o,
    input  conv_en_o,
    input  conv_in_valid_o,
    input  out_valid_o,
    input  out_last_o
  );
endinterface

// File: rtl/rgb2ycbcr_job_ctrl.sv
// Job controller for the fixed-latency RGB->YCbCr converter: accepts a
// job, gates the input stream, drives the global pipeline enable, tracks
// per-stage valid bits and signals the last output and job completion.
module rgb2ycbcr_job_ctrl #(
  parameter int CNT_WIDTH    = 16,
  parameter int PIPE_LATENCY = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 clear_i,
  input  logic [CNT_WIDTH-1:0] num_pixels_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           dbg_state_o,
  rgb2ycbcr_job_ctrl_if.master strm
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    num_q, num_d;
  logic [CNT_WIDTH-1:0]    in_cnt_q, in_cnt_d;
  logic [CNT_WIDTH-1:0]    out_cnt_q, out_cnt_d;
  logic [PIPE_LATENCY-1:0] vld_q, vld_d;

  logic out_valid;
  logic conv_en;
  logic in_ready;
  logic in_fire;
  logic out_fire;
  logic out_last;

  // Stream qualifiers: the whole pipeline stalls only when a valid
  // output is not being consumed.
  always_comb begin
    out_valid = vld_q[PIPE_LATENCY-1];
    conv_en   = ~out_valid | strm.out_ready_i;
    in_ready  = (state_q == ST_RUN) & conv_en;
    in_fire   = strm.in_valid_i & in_ready;
    out_fire  = out_valid & strm.out_ready_i;
    out_last  = out_valid & (out_cnt_q == num_q - CNT_ONE);
  end

  assign strm.out_valid_o     = out_valid;
  assign strm.conv_en_o       = conv_en;
  assign strm.in_ready_o      = in_ready;
  assign strm.conv_in_valid_o = in_fire;
  assign strm.out_last_o      = out_last;
  assign busy_o               = (state_q != ST_IDLE);
  assign done_o               = (state_q == ST_DONE);
  assign dbg_state_o          = state_q;

  // Next-state, counters and valid shift register; clear overrides all.
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    vld_d     = vld_q;

    if (conv_en) begin
      vld_d[0] = in_fire;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          num_d     = num_pixels_i;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = (num_pixels_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (in_fire) begin
          in_cnt_d = in_cnt_q + CNT_ONE;
          if (in_cnt_d == num_q) state_d = ST_DRAIN;
        end
        // Final output wins even if the final input fires the same cycle.
        if (out_fire) begin
          out_cnt_d = out_cnt_q + CNT_ONE;
          if (out_last) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (clear_i) begin
      state_d   = ST_IDLE;
      num_d     = '0;
      in_cnt_d  = '0;
      out_cnt_d = '0;
      vld_d     = '0;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      num_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      vld_q     <= vld_d;
    end
  end

endmodule

// File: doc/rgb2ycbcr_job_ctrl.md
# rgb2ycbcr_job_ctrl

Job controller for the fixed-latency RGB→YCbCr conversion pipeline. It accepts a job (pixel count + start), gates the input pixel stream into the converter, and drives the converter's global pipeline enable. It tracks per-stage valid bits, applies output backpressure by stalling the whole pipeline, marks the last output pixel, and pulses `done_o` when every pixel has left the converter. It sits between the HWPE controller/register file and the streamer-facing converter datapath. It carries no pixel data; RGB/YCbCr data paths connect directly between the streamer and the converter.

## Interface
Parameters:
- `CNT_WIDTH`, 16, width of the pixel count and internal counters.
- `PIPE_LATENCY`, 3, converter latency in enabled cycles (≥1).

Ports:
- `clk_i` in 1: clock, single domain.
- `rst_i` in 1: reset, synchronous and active-high.
- `start_i` in 1: job start; sampled only in IDLE.
- `clear_i` in 1: synchronous soft abort; priority over `start_i`.
- `num_pixels_i` in CNT_WIDTH: job length; latched when start is accepted.
- `busy_o` out 1: high in RUN, DRAIN and DONE.
- `done_o` out 1: single-cycle pulse marking job completion.
- `in_valid_i` in 1: streamer has an RGB pixel.
- `in_ready_o` out 1: controller accepts that pixel this cycle.
- `conv_en_o` out 1: converter pipeline advance enable, applied to all stages.
- `conv_in_valid_o` out 1: stage-0 capture qualifier; equals `in_valid_i & in_ready_o`.
- `out_valid_o` out 1: converter output holds a valid YCbCr pixel.
- `out_ready_i` in 1: downstream consumes the output.
- `out_last_o` out 1: the current output is the job's last pixel.

## Operation
- State register: IDLE, RUN, DRAIN, DONE. Reset and `clear_i` both force IDLE, zero all counters, and clear all valid bits.
- IDLE:
  - If `start_i & ~clear_i`: latch `num_pixels_i` into `num_q`, zero `in_cnt` and `out_cnt`.
  - Next state is RUN, or DONE if `num_pixels_i == 0`.
- `vld[PIPE_LATENCY-1:0]` is a shift register. On `conv_en_o` it shifts: `vld[0] <= conv_in_valid_o`. It holds otherwise.
- `out_valid_o = vld[PIPE_LATENCY-1]`.
- `conv_en_o = ~out_valid_o | out_ready_i`. The pipeline advances whenever the output slot is empty or is being consumed. This is combinational in every state, so it is 1 in IDLE.
- `in_ready_o = (state == RUN) & conv_en_o`. The combinational path from `out_ready_i` to `in_ready_o` is intended.
- Input fire (`in_valid_i & in_ready_o`) increments `in_cnt`.
- RUN → DRAIN on the fire that makes `in_cnt == num_q`.
- Output fire (`out_valid_o & out_ready_i`) increments `out_cnt`.
- `out_last_o = out_valid_o & (out_cnt == num_q - 1)`.
- DRAIN → DONE on the output fire where `out_last_o = 1`. This transition can also occur from RUN if the final input and final output coincide; with PIPE_LATENCY ≥ 1 this cannot happen, but the transition logic must not depend on that.
- DONE: `done_o = 1` for exactly one cycle, then IDLE.
- `start_i` outside IDLE is ignored, and no job is queued.
- Counters are CNT_WIDTH bits wide and cannot wrap, because they stop at `num_q`. The maximum job is 2^CNT_WIDTH − 1 pixels.
- `clear_i` mid-job:
  - Return to IDLE next cycle with no `done_o`.
  - Valid bits are flushed, so in-flight pixels are dropped and `out_valid_o` is 0 the next cycle.
  - The pixel presented in the `clear_i` cycle is still accepted if `in_ready_o` was 1.

## Timing
- Reset values (cycle after `rst_i`): state IDLE, `busy_o` 0, `done_o` 0, `in_ready_o` 0, `out_valid_o` 0, `out_last_o` 0, `conv_in_valid_o` 0, `conv_en_o` 1.
- Start accepted at cycle t → `busy_o` and `in_ready_o` (if not stalled) high at t+1.
- Without stalls, a pixel accepted at cycle k has `out_valid_o` at k+PIPE_LATENCY.
- With `in_valid_i` and `out_ready_i` held high, throughput is 1 pixel/cycle.
- N-pixel job with no stalls, start at t:
  - last input at t+N;
  - last output at t+N+PIPE_LATENCY;
  - `done_o` at t+N+PIPE_LATENCY+1;
  - `busy_o` low at t+N+PIPE_LATENCY+2.
- Zero-length job: start at t → DONE at t+1 (`done_o`, `busy_o` high) → IDLE at t+2. No input is accepted.
- Stall: when `out_valid_o=1` and `out_ready_i=0`, `conv_en_o=0` and `in_ready_o=0`. All `vld` bits and the output hold stable.

## Test plan
- Basic job, `num_pixels_i=4`, PIPE_LATENCY=3, start at cycle 0, streams always ready → `in_ready_o` high cycles 1–4; `out_valid_o` cycles 4–7; `out_last_o` only at cycle 7; `done_o` pulse at cycle 8; `busy_o` low at 9.
- Same job with `out_ready_i` low during cycles 5–6 → `conv_en_o` and `in_ready_o` low in those cycles; outputs hold; four output fires total; `done_o` delayed by 2 cycles (cycle 10).
- `num_pixels_i=0` → `done_o` one cycle after start; `in_ready_o` never asserts; no output.
- `start_i` pulsed again mid-job with `num_pixels_i=9` → ignored; the job completes with the original count 4; exactly one `done_o`.
- `clear_i` asserted after 2 inputs accepted → IDLE next cycle; `out_valid_o`=0; no `done_o`; a following start of 3 pixels completes normally.
- `rst_i` asserted mid-drain, together with `start_i` → all outputs at reset values next cycle; start is not latched.
